// File: rtl/ct_iu_div_entry_lookup_pkg.sv
// rtl/ct_iu_div_entry_lookup_pkg.sv - shared FSM encoding and divide-entry field layout
package ct_iu_div_entry_lookup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_BUSY   = 2'd2,
    ST_WB     = 2'd3
  } div_state_e;

  localparam int DATA_W       = 64;
  localparam int ENTRY_W      = 258;
  localparam int DIVIDEND_LSB = 0;
  localparam int DIVISOR_LSB  = 64;
  localparam int QUO_LSB      = 128;
  localparam int REM_LSB      = 192;
  localparam int SIGNED_BIT   = 256;
  localparam int WORD_BIT     = 257;

endpackage

// File: rtl/ct_iu_div_entry_lookup_cmp.sv
// rtl/ct_iu_div_entry_lookup_cmp.sv - operand match of one cached divide entry
module ct_iu_div_entry_cmp (
  input  logic        entry_disable,
  input  logic [63:0] entry_dividend,
  input  logic [63:0] entry_divisor,
  input  logic        entry_signed,
  input  logic        entry_word,
  input  logic [63:0] op_src0,
  input  logic [63:0] op_src1,
  input  logic        op_signed,
  input  logic        op_word,
  output logic        hit
);

  assign hit = !entry_disable
            && (entry_dividend == op_src0)
            && (entry_divisor  == op_src1)
            && (entry_signed   == op_signed)
            && (entry_word     == op_word);

endmodule

// File: rtl/ct_iu_div_entry_lookup.sv
// rtl/ct_iu_div_entry_lookup.sv - divide result cache lookup in front of the iterative divider
module ct_iu_div_entry_lookup
  import ct_iu_div_entry_lookup_pkg::*;
(
  input  logic         div_clk,
  input  logic         cpurst_b,
  input  logic         cp0_iu_div_entry_disable,
  input  logic         rtu_yy_xx_flush,
  input  logic         idu_iu_div_sel,
  input  logic [63:0]  idu_iu_div_src0,
  input  logic [63:0]  idu_iu_div_src1,
  input  logic         idu_iu_div_signed,
  input  logic         idu_iu_div_word,
  input  logic         idu_iu_div_rem_sel,
  input  logic [6:0]   idu_iu_div_iid,
  output logic         div_iu_busy,
  input  logic [257:0] div_entry0_read_data,
  input  logic [257:0] div_entry1_read_data,
  output logic         div_entry0_read_vld,
  output logic         div_entry1_read_vld,
  output logic         div_entry_write_en,
  output logic [257:0] div_entry_write_data,
  output logic         div_core_start,
  output logic         div_core_kill,
  output logic [63:0]  div_core_src0,
  output logic [63:0]  div_core_src1,
  output logic         div_core_signed,
  output logic         div_core_word,
  input  logic         div_core_done,
  input  logic [63:0]  div_core_quotient,
  input  logic [63:0]  div_core_remainder,
  output logic         iu_rbus_div_vld,
  output logic [63:0]  iu_rbus_div_data,
  output logic [6:0]   iu_rbus_div_iid
);

  div_state_e  state_q, state_d;
  logic [63:0] src0_q, src0_d, src1_q, src1_d;
  logic [63:0] quo_q, quo_d, rem_q, rem_d;
  logic        signed_q, signed_d, word_q, word_d, rem_sel_q, rem_sel_d, miss_q, miss_d;
  logic [6:0]  iid_q, iid_d;
  logic        hit0, hit1;

  ct_iu_div_entry_cmp u_cmp0 (
    .entry_disable  (cp0_iu_div_entry_disable),
    .entry_dividend (div_entry0_read_data[DIVIDEND_LSB +: DATA_W]),
    .entry_divisor  (div_entry0_read_data[DIVISOR_LSB +: DATA_W]),
    .entry_signed   (div_entry0_read_data[SIGNED_BIT]),
    .entry_word     (div_entry0_read_data[WORD_BIT]),
    .op_src0        (src0_q),
    .op_src1        (src1_q),
    .op_signed      (signed_q),
    .op_word        (word_q),
    .hit            (hit0)
  );

  ct_iu_div_entry_cmp u_cmp1 (
    .entry_disable  (cp0_iu_div_entry_disable),
    .entry_dividend (div_entry1_read_data[DIVIDEND_LSB +: DATA_W]),
    .entry_divisor  (div_entry1_read_data[DIVISOR_LSB +: DATA_W]),
    .entry_signed   (div_entry1_read_data[SIGNED_BIT]),
    .entry_word     (div_entry1_read_data[WORD_BIT]),
    .op_src0        (src0_q),
    .op_src1        (src1_q),
    .op_signed      (signed_q),
    .op_word        (word_q),
    .hit            (hit1)
  );

  always_ff @(posedge div_clk) begin
    if (!cpurst_b) begin
      state_q   <= ST_IDLE;
      src0_q    <= '0;
      src1_q    <= '0;
      signed_q  <= 1'b0;
      word_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      iid_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src0_q    <= src0_d;
      src1_q    <= src1_d;
      signed_q  <= signed_d;
      word_q    <= word_d;
      rem_sel_q <= rem_sel_d;
      iid_q     <= iid_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      miss_q    <= miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src0_d    = src0_q;
    src1_d    = src1_q;
    signed_d  = signed_q;
    word_d    = word_q;
    rem_sel_d = rem_sel_q;
    iid_d     = iid_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    miss_d    = miss_q;
    case (state_q)
      ST_IDLE: begin
        if (idu_iu_div_sel && !rtu_yy_xx_flush) begin
          src0_d    = idu_iu_div_src0;
          src1_d    = idu_iu_div_src1;
          signed_d  = idu_iu_div_signed;
          word_d    = idu_iu_div_word;
          rem_sel_d = idu_iu_div_rem_sel;
          iid_d     = idu_iu_div_iid;
          state_d   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // Entry0 is checked first so it wins when both entries match.
        if (rtu_yy_xx_flush) begin
          state_d = ST_IDLE;
        end else if (hit0) begin
          quo_d   = div_entry0_read_data[QUO_LSB +: DATA_W];
          rem_d   = div_entry0_read_data[REM_LSB +: DATA_W];
          miss_d  = 1'b0;
          state_d = ST_WB;
        end else if (hit1) begin
          quo_d   = div_entry1_read_data[QUO_LSB +: DATA_W];
          rem_d   = div_entry1_read_data[REM_LSB +: DATA_W];
          miss_d  = 1'b0;
          state_d = ST_WB;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rtu_yy_xx_flush) begin
          state_d = ST_IDLE;
        end else if (div_core_done) begin
          quo_d   = div_core_quotient;
          rem_d   = div_core_remainder;
          miss_d  = 1'b1;
          state_d = ST_WB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output is qualified by cpurst_b so a reset cycle never leaks a pulse.
  always_comb begin
    div_iu_busy          = 1'b0;
    div_entry0_read_vld  = 1'b0;
    div_entry1_read_vld  = 1'b0;
    div_entry_write_en   = 1'b0;
    div_entry_write_data = '0;
    div_core_start       = 1'b0;
    div_core_kill        = 1'b0;
    div_core_src0        = '0;
    div_core_src1        = '0;
    div_core_signed      = 1'b0;
    div_core_word        = 1'b0;
    iu_rbus_div_vld      = 1'b0;
    iu_rbus_div_data     = '0;
    iu_rbus_div_iid      = '0;
    if (cpurst_b) begin
      div_iu_busy = (state_q != ST_IDLE);
      if (state_q == ST_LOOKUP && !rtu_yy_xx_flush) begin
        div_entry0_read_vld = hit0;
        div_entry1_read_vld = !hit0 && hit1;
        div_core_start      = !hit0 && !hit1;
      end
      if (state_q == ST_LOOKUP || state_q == ST_BUSY) begin
        div_core_src0   = src0_q;
        div_core_src1   = src1_q;
        div_core_signed = signed_q;
        div_core_word   = word_q;
      end
      div_core_kill = (state_q == ST_BUSY) && rtu_yy_xx_flush;
      if (state_q == ST_WB) begin
        if (!rtu_yy_xx_flush) begin
          iu_rbus_div_vld  = 1'b1;
          iu_rbus_div_data = rem_sel_q ? rem_q : quo_q;
          iu_rbus_div_iid  = iid_q;
        end
        if (miss_q && !cp0_iu_div_entry_disable) begin
          div_entry_write_en   = 1'b1;
          div_entry_write_data = {word_q, signed_q, rem_q, quo_q, src1_q, src0_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_ct_iu_div_entry_lookup.sv
// tb/tb_ct_iu_div_entry_lookup.sv - scoreboard bench for the divide entry lookup
module tb_ct_iu_div_entry_lookup;

  logic         div_clk, cpurst_b, cp0_iu_div_entry_disable, rtu_yy_xx_flush;
  logic         idu_iu_div_sel, idu_iu_div_signed, idu_iu_div_word, idu_iu_div_rem_sel;
  logic [63:0]  idu_iu_div_src0, idu_iu_div_src1;
  logic [6:0]   idu_iu_div_iid;
  logic         div_iu_busy;
  logic [257:0] div_entry0_read_data, div_entry1_read_data;
  logic         div_entry0_read_vld, div_entry1_read_vld, div_entry_write_en;
  logic [257:0] div_entry_write_data;
  logic         div_core_start, div_core_kill, div_core_signed, div_core_word, div_core_done;
  logic [63:0]  div_core_src0, div_core_src1, div_core_quotient, div_core_remainder;
  logic         iu_rbus_div_vld;
  logic [63:0]  iu_rbus_div_data;
  logic [6:0]   iu_rbus_div_iid;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [70:0]  rbus_q[$];
  logic [257:0] wr_q[$];

  logic [257:0] entry_mem [2];
  logic         wr_ptr;
  logic [63:0]  core_q, core_r;
  int           core_lat;
  int           core_cnt;

  ct_iu_div_entry_lookup dut (
    .div_clk(div_clk), .cpurst_b(cpurst_b),
    .cp0_iu_div_entry_disable(cp0_iu_div_entry_disable), .rtu_yy_xx_flush(rtu_yy_xx_flush),
    .idu_iu_div_sel(idu_iu_div_sel), .idu_iu_div_src0(idu_iu_div_src0),
    .idu_iu_div_src1(idu_iu_div_src1), .idu_iu_div_signed(idu_iu_div_signed),
    .idu_iu_div_word(idu_iu_div_word), .idu_iu_div_rem_sel(idu_iu_div_rem_sel),
    .idu_iu_div_iid(idu_iu_div_iid), .div_iu_busy(div_iu_busy),
    .div_entry0_read_data(div_entry0_read_data), .div_entry1_read_data(div_entry1_read_data),
    .div_entry0_read_vld(div_entry0_read_vld), .div_entry1_read_vld(div_entry1_read_vld),
    .div_entry_write_en(div_entry_write_en), .div_entry_write_data(div_entry_write_data),
    .div_core_start(div_core_start), .div_core_kill(div_core_kill),
    .div_core_src0(div_core_src0), .div_core_src1(div_core_src1),
    .div_core_signed(div_core_signed), .div_core_word(div_core_word),
    .div_core_done(div_core_done), .div_core_quotient(div_core_quotient),
    .div_core_remainder(div_core_remainder), .iu_rbus_div_vld(iu_rbus_div_vld),
    .iu_rbus_div_data(iu_rbus_div_data), .iu_rbus_div_iid(iu_rbus_div_iid)
  );

  initial begin
    div_clk = 1'b0;
    forever #5 div_clk = ~div_clk;
  end

  task automatic check(input string name, input logic [257:0] act, input logic [257:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Entry storage with round-robin replacement, starting at entry1.
  assign div_entry0_read_data = entry_mem[0];
  assign div_entry1_read_data = entry_mem[1];
  always @(posedge div_clk) begin
    if (div_entry_write_en) begin
      entry_mem[wr_ptr] <= div_entry_write_data;
      wr_ptr <= ~wr_ptr;
    end
  end

  // Behavioral divider: returns core_q/core_r core_lat cycles after start.
  always @(posedge div_clk) begin
    if (!cpurst_b || div_core_kill) begin
      core_cnt      <= 0;
      div_core_done <= 1'b0;
    end else begin
      div_core_done <= 1'b0;
      if (div_core_start) core_cnt <= core_lat;
      else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          div_core_done      <= 1'b1;
          div_core_quotient  <= core_q;
          div_core_remainder <= core_r;
        end
      end
    end
  end

  always begin
    @(negedge div_clk);
    #2;
    if (iu_rbus_div_vld) begin
      if (rbus_q.size() == 0) check("rbus_unexpected", {iu_rbus_div_iid, iu_rbus_div_data}, 0);
      else begin
        logic [70:0] e;
        e = rbus_q.pop_front();
        check("rbus_data", iu_rbus_div_data, e[63:0]);
        check("rbus_iid", iu_rbus_div_iid, e[70:64]);
      end
    end
    if (div_entry_write_en) begin
      if (wr_q.size() == 0) check("write_unexpected", div_entry_write_data, 0);
      else check("write_data", div_entry_write_data, wr_q.pop_front());
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (div_iu_busy && n < 200) begin @(negedge div_clk); n++; end
    if (div_iu_busy) fail_now("idle_timeout");
  endtask

  // kind: 0 hit entry0, 1 hit entry1, 2 miss, 3 flushed in LOOKUP
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sg, input logic wd,
                       input logic rs, input logic [6:0] id, input int kind,
                       input logic [63:0] exp_data, input bit exp_rbus, input bit exp_wr,
                       input bit hold);
    wait_idle();
    idu_iu_div_sel = 1'b1;
    idu_iu_div_src0 = a; idu_iu_div_src1 = b;
    idu_iu_div_signed = sg; idu_iu_div_word = wd; idu_iu_div_rem_sel = rs;
    idu_iu_div_iid = id;
    if (exp_rbus) rbus_q.push_back({id, exp_data});
    if (exp_wr) wr_q.push_back({wd, sg, core_r, core_q, b, a});
    @(negedge div_clk);
    if (!hold) idu_iu_div_sel = 1'b0;
    if (kind == 3) rtu_yy_xx_flush = 1'b1;
    #1;
    check("read_vld0", div_entry0_read_vld, kind == 0);
    check("read_vld1", div_entry1_read_vld, kind == 1);
    check("core_start", div_core_start, kind == 2);
    if (kind == 2) begin
      check("core_src0", div_core_src0, a);
      check("core_src1", div_core_src1, b);
      check("core_attr", {div_core_signed, div_core_word}, {sg, wd});
    end
    if (kind == 3) begin
      @(negedge div_clk);
      rtu_yy_xx_flush = 1'b0;
      #1 check("busy_after_lookup_flush", div_iu_busy, 0);
    end
  endtask

  initial begin
    int n;
    entry_mem[0] = {1'b0, 1'b0, 64'h0, 64'hffff_ffff_ffff_ffff, 64'h1, 64'hffff_ffff_ffff_ffff};
    entry_mem[1] = {1'b0, 1'b1, 64'h0, 64'h7fff_ffff_ffff_ffff, 64'h1, 64'h7fff_ffff_ffff_ffff};
    wr_ptr = 1'b1;
    core_q = '0; core_r = '0; core_lat = 2;
    cpurst_b = 1'b0; cp0_iu_div_entry_disable = 1'b0; rtu_yy_xx_flush = 1'b0;
    idu_iu_div_sel = 1'b0; idu_iu_div_src0 = '0; idu_iu_div_src1 = '0;
    idu_iu_div_signed = 1'b0; idu_iu_div_word = 1'b0; idu_iu_div_rem_sel = 1'b0;
    idu_iu_div_iid = '0;
    repeat (3) @(negedge div_clk);
    #1;
    check("reset_busy", div_iu_busy, 0);
    check("reset_pulses", {div_entry0_read_vld, div_entry1_read_vld, div_entry_write_en,
                           div_core_start, div_core_kill, iu_rbus_div_vld}, 0);
    check("reset_buses", {div_core_src0, div_core_src1, iu_rbus_div_data, iu_rbus_div_iid}, 0);
    @(negedge div_clk);
    cpurst_b = 1'b1;

    issue(64'hffff_ffff_ffff_ffff, 64'h1, 0, 0, 0, 7'd1, 0, 64'hffff_ffff_ffff_ffff, 1, 0, 0);

    core_q = 64'd14; core_r = 64'd2;
    issue(64'd100, 64'd7, 1, 0, 0, 7'd2, 2, 64'd14, 1, 1, 0);
    issue(64'd100, 64'd7, 1, 0, 1, 7'd3, 1, 64'd2, 1, 0, 0);

    // Request held across a busy miss: the second op only enters after idle.
    core_q = 64'd16; core_r = 64'd2;
    issue(64'd50, 64'd3, 0, 0, 0, 7'd4, 2, 64'd16, 1, 1, 1);
    idu_iu_div_src0 = 64'd100; idu_iu_div_src1 = 64'd7; idu_iu_div_signed = 1'b1;
    idu_iu_div_iid = 7'd5;
    rbus_q.push_back({7'd5, 64'd14});
    @(negedge div_clk);
    check("busy_while_held", div_iu_busy, 1);
    wait_idle();
    @(negedge div_clk);
    idu_iu_div_sel = 1'b0;
    #1 check("held_read_vld1", div_entry1_read_vld, 1);

    cp0_iu_div_entry_disable = 1'b1;
    core_q = 64'd14; core_r = 64'd2;
    issue(64'd100, 64'd7, 1, 0, 1, 7'd6, 2, 64'd2, 1, 0, 0);
    wait_idle();
    cp0_iu_div_entry_disable = 1'b0;

    issue(64'd50, 64'd3, 0, 0, 0, 7'd7, 3, 64'd0, 0, 0, 0);

    core_lat = 6;
    issue(64'd9, 64'd0, 0, 0, 0, 7'd8, 2, 64'd0, 0, 0, 0);
    @(negedge div_clk);
    @(negedge div_clk);
    rtu_yy_xx_flush = 1'b1;
    #1 check("busy_flush_kill", div_core_kill, 1);
    @(negedge div_clk);
    rtu_yy_xx_flush = 1'b0;
    #1 check("busy_after_kill", div_iu_busy, 0);

    core_lat = 2; core_q = 64'hffff_ffff_ffff_ffff; core_r = 64'd9;
    issue(64'd9, 64'd0, 0, 0, 0, 7'd9, 2, 64'hffff_ffff_ffff_ffff, 1, 1, 0);
    issue(64'd9, 64'd0, 0, 0, 1, 7'd10, 1, 64'd9, 1, 0, 0);

    core_q = 64'd4; core_r = 64'd0;
    issue(64'd8, 64'd2, 1, 0, 0, 7'd11, 2, 64'd0, 0, 1, 0);
    n = 0;
    while (!div_core_done && n < 50) begin @(negedge div_clk); n++; end
    if (!div_core_done) fail_now("done_timeout");
    @(negedge div_clk);
    rtu_yy_xx_flush = 1'b1;
    #1;
    check("wb_flush_vld", iu_rbus_div_vld, 0);
    check("wb_flush_write", div_entry_write_en, 1);
    @(negedge div_clk);
    rtu_yy_xx_flush = 1'b0;

    core_q = 64'd3; core_r = 64'd2;
    issue(64'd20, 64'd6, 0, 1, 1, 7'd12, 2, 64'd2, 1, 1, 0);

    core_lat = 6;
    issue(64'd77, 64'd5, 0, 0, 0, 7'd13, 2, 64'd0, 0, 0, 0);
    @(negedge div_clk);
    @(negedge div_clk);
    cpurst_b = 1'b0;
    rtu_yy_xx_flush = 1'b1;
    #1;
    check("reset_mid_kill", div_core_kill, 0);
    check("reset_mid_busy", div_iu_busy, 0);
    @(negedge div_clk);
    cpurst_b = 1'b1;
    rtu_yy_xx_flush = 1'b0;
    #1 check("reset_mid_idle", div_iu_busy, 0);

    repeat (10) @(negedge div_clk);
    #3;
    check("rbus_queue_drained", rbus_q.size(), 0);
    check("write_queue_drained", wr_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/ct_iu_div_entry_lookup.md
CT_IU_DIV_ENTRY_LOOKUP -- requirements
Module: ct_iu_div_entry_lookup

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; ports named div_clk and cpurst_b.
REQ-002 SHALL have ports, as name direction width meaning:
- div_clk  in  1  clock.
- cpurst_b  in  1  sync active-low reset.
- cp0_iu_div_entry_disable  in  1  force miss, suppress entry write.
- rtu_yy_xx_flush  in  1  kill in-flight op.
- idu_iu_div_sel  in  1  request valid.
- idu_iu_div_src0 / idu_iu_div_src1  in  64 each  dividend / divisor, already extended.
- idu_iu_div_signed, idu_iu_div_word, idu_iu_div_rem_sel  in  1 each  op attributes.
- idu_iu_div_iid  in  7  instruction id.
- div_iu_busy  out  1  request not accepted while high.
- div_entry0_read_data / div_entry1_read_data  in  258 each  cached entries.
- div_entry0_read_vld / div_entry1_read_vld  out  1 each  hit pulse.
- div_entry_write_en  out  1  entry write pulse.
- div_entry_write_data  out  258  entry write payload.
- div_core_start, div_core_kill  out  1 each  divider control.
- div_core_src0 / div_core_src1  out  64 each  divider operands.
- div_core_signed, div_core_word  out  1 each  divider attributes.
- div_core_done  in  1  divider result valid.
- div_core_quotient / div_core_remainder  in  64 each  divider result.
- iu_rbus_div_vld  out  1  result valid.
- iu_rbus_div_data  out  64  result data.
- iu_rbus_div_iid  out  7  result id.

Function
REQ-003 Entry layout SHALL be [257] word, [256] signed, [255:192] remainder, [191:128] quotient, [127:64] divisor, [63:0] dividend.
REQ-004 FSM states SHALL be IDLE, LOOKUP, BUSY, WB; div_iu_busy SHALL equal (state != IDLE).
REQ-005 In IDLE with idu_iu_div_sel=1 and no flush, the block SHALL latch src0, src1, signed, word, rem_sel, and iid, then go to LOOKUP.
REQ-006 Entry N SHALL hit when its dividend, divisor, signed, and word fields all equal the latched operands and cp0_iu_div_entry_disable=0.
REQ-007 On a LOOKUP hit, the block SHALL pulse div_entryN_read_vld that cycle, register the entry's quotient or remainder (per rem_sel), and go to WB.
- Entry0 SHALL win when both entries hit.
REQ-008 On a LOOKUP miss, the block SHALL pulse div_core_start for one cycle, drive the div_core_* operands from the latched values (held until leaving BUSY), and go to BUSY.
REQ-009 In BUSY with div_core_done=1, the block SHALL register the quotient and remainder, set a miss flag, and go to WB.
REQ-010 In WB, the block SHALL assert iu_rbus_div_vld for one cycle with data and iid, then go to IDLE.
- Hit latency SHALL be 2 cycles from the accept edge.
- Miss latency SHALL be 1 cycle after div_core_done.
REQ-011 In WB with the miss flag set and disable=0, the block SHALL pulse div_entry_write_en with payload {word, signed, remainder, quotient, divisor, dividend}.
REQ-012 Flush in LOOKUP SHALL return the FSM to IDLE with no read_vld, no core start, and no result.
REQ-013 Flush in BUSY SHALL pulse div_core_kill and return the FSM to IDLE with no result and no write.
REQ-014 Flush in WB SHALL suppress iu_rbus_div_vld; div_entry_write_en SHALL still occur per REQ-011.
REQ-015 Flush in IDLE SHALL drop a concurrent request.
REQ-016 Divide-by-zero and overflow results from the core SHALL be forwarded and cached unmodified.

Reset
REQ-017 Reset SHALL set the FSM to IDLE and drive all outputs to 0, including all pulses, data buses, and div_iu_busy.
REQ-018 Reset asserted mid-operation SHALL abandon the op without a kill pulse or a write.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding and the entry field offsets and widths from REQ-003.
REQ-020 The entry comparator SHALL be a sub-module, ct_iu_div_entry_cmp, instanced once per entry.

Verification
REQ-021 Entries hold reset contents (entry0 unsigned 0xffffffffffffffff/1, entry1 signed 0x7fffffffffffffff/1); issue unsigned 0xffffffffffffffff/1, rem_sel=0 at T -> div_entry0_read_vld at T+1, iu_rbus_div_data=0xffffffffffffffff at T+2, no div_core_start.
REQ-022 Issue signed 100/7, rem_sel=0 -> miss, div_core_start at T+1; core done q=14 r=2 at cycle D -> at D+1 rbus data=14, write_en with payload {0,1,2,14,7,100}. After that entry is written back, 100/7 with rem_sel=1 -> hit, data=2.
REQ-023 Flush during BUSY -> div_core_kill pulse, no iu_rbus_div_vld, no write_en; the next request is accepted one cycle later.
REQ-024 disable=1 with matching operands -> no read_vld, divider used, result returned, no write_en.
REQ-025 idu_iu_div_sel held during BUSY -> ignored; accepted only once div_iu_busy=0.
